// File: rtl/complete_stage_pkg.sv
//------------------------------------------------------------------------------
// Module   : complete_stage_pkg
// Purpose  : Shared system definitions for the complete stage. Holds the
//            machine widths, the functional-unit result entry, the PRF write
//            packet and a helper that decides whether a result writes a
//            register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package complete_stage_pkg;

  localparam int XLEN           = 32;
  localparam int PHYS_REG_SZ    = 64;
  localparam int ROB_SZ         = 32;
  localparam int NUM_FU_DEFAULT = 4;

  localparam int TAG_W     = $clog2(PHYS_REG_SZ);
  localparam int ROB_IDX_W = $clog2(ROB_SZ);

  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    logic                 has_dest;
    logic [XLEN-1:0]      data;
    logic [ROB_IDX_W-1:0] rob_idx;
  } FU_RESULT_ENTRY;

  typedef struct packed {
    logic             write_en;
    logic [TAG_W-1:0] write_tag;
    logic [XLEN-1:0]  write_data;
  } IC_PRF_PACKET;

  // Physical register 0 is hard-wired, so a result targeting it never
  // produces a register write or a tag broadcast.
  function automatic logic writes_reg(input FU_RESULT_ENTRY e);
    return e.has_dest && (e.tag != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fu_result_fifo.sv
//------------------------------------------------------------------------------
// Module   : fu_result_fifo
// Purpose  : Small result FIFO sitting between one functional unit and the
//            completion arbiter.
// Ports    : clock, reset (async, active-low), squash (sync flush)
//            push_valid/push_ready/push_entry : FU-side handshake
//            pop                               : arbiter removes the head
//            head_valid/head_entry             : oldest buffered result
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fu_result_fifo
  import complete_stage_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           squash,
  input  logic           push_valid,
  output logic           push_ready,
  input  FU_RESULT_ENTRY push_entry,
  input  logic           pop,
  output logic           head_valid,
  output FU_RESULT_ENTRY head_entry
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  FU_RESULT_ENTRY   mem [FIFO_DEPTH];

  logic do_push;
  logic do_pop;

  // Ready looks only at the registered count, so a full FIFO refuses a push
  // even in a cycle where its head is being popped.
  assign push_ready = (count < CNT_W'(FIFO_DEPTH));
  assign head_valid = (count != '0);
  assign head_entry = mem[head];

  assign do_push = push_valid && push_ready && !squash;
  assign do_pop  = pop && head_valid && !squash;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // Depth is a power of two, so pointer overflow is the modulo wrap.
      if (do_push) tail <= tail + PTR_W'(1);
      if (do_pop)  head <= head + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while count covers them.
  always_ff @(posedge clock) begin
    if (do_push) mem[tail] <= push_entry;
  end

endmodule

`default_nettype wire

// File: rtl/complete_stage.sv
//------------------------------------------------------------------------------
// Module   : complete_stage
// Purpose  : Serialises functional-unit results onto the single PRF write
//            port, the CDB tag broadcast and the ROB completion port, one
//            result per cycle, using per-FU result FIFOs and a round-robin
//            arbiter.
// Ports    : clock, reset (async, active-low), squash (sync flush)
//            fu_valid/fu_ready, fu_tag, fu_has_dest, fu_data, fu_rob_idx
//            ic_prf_packet (write_en/write_tag/write_data)
//            cdb_valid/cdb_tag, rob_cmp_valid/rob_cmp_idx
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module complete_stage
  import complete_stage_pkg::*;
#(
  parameter int NUM_FU     = NUM_FU_DEFAULT,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  logic [NUM_FU-1:0]                fu_valid,
  output logic [NUM_FU-1:0]                fu_ready,
  input  logic [NUM_FU-1:0][TAG_W-1:0]     fu_tag,
  input  logic [NUM_FU-1:0]                fu_has_dest,
  input  logic [NUM_FU-1:0][XLEN-1:0]      fu_data,
  input  logic [NUM_FU-1:0][ROB_IDX_W-1:0] fu_rob_idx,
  output IC_PRF_PACKET                     ic_prf_packet,
  output logic                             cdb_valid,
  output logic [TAG_W-1:0]                 cdb_tag,
  output logic                             rob_cmp_valid,
  output logic [ROB_IDX_W-1:0]             rob_cmp_idx
);

  localparam int RR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] head_valid;
  logic [NUM_FU-1:0] pop;
  FU_RESULT_ENTRY    head_entry [NUM_FU];

  logic [RR_W-1:0] rr_ptr;
  logic [RR_W-1:0] rr_next;
  logic [RR_W-1:0] grant_idx;
  logic            grant_valid;
  FU_RESULT_ENTRY  grant_entry;

  generate
    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
      FU_RESULT_ENTRY push_entry;
      assign push_entry.tag      = fu_tag[i];
      assign push_entry.has_dest = fu_has_dest[i];
      assign push_entry.data     = fu_data[i];
      assign push_entry.rob_idx  = fu_rob_idx[i];

      fu_result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .squash     (squash),
        .push_valid (fu_valid[i]),
        .push_ready (fu_ready[i]),
        .push_entry (push_entry),
        .pop        (pop[i]),
        .head_valid (head_valid[i]),
        .head_entry (head_entry[i])
      );
    end
  endgenerate

  // Scan offsets from highest to lowest so the surviving assignment is the
  // first non-empty FIFO at or after rr_ptr. Squash suppresses the grant so
  // neither the outputs nor rr_ptr move during a flush.
  always_comb begin : p_arb
    int cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_FU) cand = cand - NUM_FU;
      if (head_valid[RR_W'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = RR_W'(cand);
      end
    end
    if (squash) grant_valid = 1'b0;
  end

  always_comb begin
    pop = '0;
    if (grant_valid) pop[grant_idx] = 1'b1;
  end

  assign rr_next     = (grant_idx == RR_W'(NUM_FU - 1)) ? '0 : grant_idx + RR_W'(1);
  assign grant_entry = head_entry[grant_idx];

  // The granted head is captured at the same edge it leaves its FIFO; data
  // and tag fields keep their last value when nothing completes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr        <= '0;
      ic_prf_packet <= '0;
      cdb_valid     <= 1'b0;
      cdb_tag       <= '0;
      rob_cmp_valid <= 1'b0;
      rob_cmp_idx   <= '0;
    end else if (grant_valid) begin
      rr_ptr                   <= rr_next;
      rob_cmp_valid            <= 1'b1;
      rob_cmp_idx              <= grant_entry.rob_idx;
      ic_prf_packet.write_en   <= writes_reg(grant_entry);
      ic_prf_packet.write_tag  <= grant_entry.tag;
      ic_prf_packet.write_data <= grant_entry.data;
      cdb_valid                <= writes_reg(grant_entry);
      cdb_tag                  <= grant_entry.tag;
    end else begin
      rob_cmp_valid          <= 1'b0;
      ic_prf_packet.write_en <= 1'b0;
      cdb_valid              <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_complete_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_complete_stage
// Purpose  : Directed self-checking bench for complete_stage: reset values,
//            single result, tag-0 / no-destination results, back-pressure,
//            squash, asynchronous reset and full four-way contention.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_complete_stage;
  import complete_stage_pkg::*;

  localparam int NFU = 4;

  logic                          clock = 1'b0;
  logic                          reset;
  logic                          squash;
  logic [NFU-1:0]                fu_valid;
  logic [NFU-1:0]                fu_ready;
  logic [NFU-1:0][TAG_W-1:0]     fu_tag;
  logic [NFU-1:0]                fu_has_dest;
  logic [NFU-1:0][XLEN-1:0]      fu_data;
  logic [NFU-1:0][ROB_IDX_W-1:0] fu_rob_idx;
  IC_PRF_PACKET                  ic_prf_packet;
  logic                          cdb_valid;
  logic [TAG_W-1:0]              cdb_tag;
  logic                          rob_cmp_valid;
  logic [ROB_IDX_W-1:0]          rob_cmp_idx;

  int tests = 0;
  int fails = 0;

  complete_stage #(.NUM_FU(NFU), .FIFO_DEPTH(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .squash        (squash),
    .fu_valid      (fu_valid),
    .fu_ready      (fu_ready),
    .fu_tag        (fu_tag),
    .fu_has_dest   (fu_has_dest),
    .fu_data       (fu_data),
    .fu_rob_idx    (fu_rob_idx),
    .ic_prf_packet (ic_prf_packet),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .rob_cmp_valid (rob_cmp_valid),
    .rob_cmp_idx   (rob_cmp_idx)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [TAG_W-1:0] tag, input logic hd,
                        input logic [XLEN-1:0] d, input logic [ROB_IDX_W-1:0] rob);
    fu_tag[i]      = tag;
    fu_has_dest[i] = hd;
    fu_data[i]     = d;
    fu_rob_idx[i]  = rob;
  endtask

  // Full completion check for a cycle where a result is expected.
  task automatic check_cmp(input string name, input logic [ROB_IDX_W-1:0] rob,
                           input logic we, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] d);
    check({name, ".rob_valid"}, 64'(rob_cmp_valid), 64'(1'b1));
    check({name, ".rob_idx"}, 64'(rob_cmp_idx), 64'(rob));
    check({name, ".write_en"}, 64'(ic_prf_packet.write_en), 64'(we));
    check({name, ".cdb_valid"}, 64'(cdb_valid), 64'(we));
    check({name, ".write_tag"}, 64'(ic_prf_packet.write_tag), 64'(tag));
    check({name, ".cdb_tag"}, 64'(cdb_tag), 64'(tag));
    check({name, ".write_data"}, 64'(ic_prf_packet.write_data), 64'(d));
  endtask

  task automatic check_idle(input string name);
    check({name, ".rob_valid"}, 64'(rob_cmp_valid), 64'(1'b0));
    check({name, ".write_en"}, 64'(ic_prf_packet.write_en), 64'(1'b0));
    check({name, ".cdb_valid"}, 64'(cdb_valid), 64'(1'b0));
  endtask

  logic [2:0]     seq [NFU];
  logic [NFU-1:0] acc;
  int             efu;
  int             eseq;

  initial begin
    reset       = 1'b0;
    squash      = 1'b0;
    fu_valid    = '0;
    fu_tag      = '0;
    fu_has_dest = '0;
    fu_data     = '0;
    fu_rob_idx  = '0;

    // ---------------- reset values (before any clock edge) ----------------
    #3;
    check("rst.fu_ready", 64'(fu_ready), 64'(4'hF));
    check_idle("rst");
    check("rst.write_tag", 64'(ic_prf_packet.write_tag), 64'd0);
    check("rst.write_data", 64'(ic_prf_packet.write_data), 64'd0);
    check("rst.cdb_tag", 64'(cdb_tag), 64'd0);
    check("rst.rob_idx", 64'(rob_cmp_idx), 64'd0);
    tick();
    tick();
    reset = 1'b1;

    // ---------------- single result from FU1 ----------------
    set_fu(1, 6'd5, 1'b1, 32'hDEADBEEF, 5'd3);
    fu_valid = 4'b0010;
    tick();
    fu_valid = '0;
    check_idle("single.pushed");
    tick();
    check_cmp("single", 5'd3, 1'b1, 6'd5, 32'hDEADBEEF);
    tick();
    check_idle("single.after");
    check("single.data_hold", 64'(ic_prf_packet.write_data), 64'h0DEADBEEF);
    // rr_ptr = 2

    // ---------------- no destination / tag 0 ----------------
    set_fu(0, 6'd7, 1'b0, 32'h11111111, 5'd9);
    set_fu(3, 6'd0, 1'b1, 32'h33333333, 5'd10);
    fu_valid = 4'b1001;
    tick();
    fu_valid = '0;
    tick();
    check_cmp("tag0", 5'd10, 1'b0, 6'd0, 32'h33333333);
    tick();
    check_cmp("nodest", 5'd9, 1'b0, 6'd7, 32'h11111111);
    tick();
    check_idle("nodest.after");
    // rr_ptr = 1

    // ---------------- back-pressure ----------------
    set_fu(0, 6'd10, 1'b1, 32'h000000A0, 5'd1);
    set_fu(3, 6'd11, 1'b1, 32'h00000030, 5'd2);
    fu_valid = 4'b1001;
    tick();
    check_idle("bp.a");
    set_fu(0, 6'd12, 1'b1, 32'h000000B0, 5'd3);
    set_fu(2, 6'd20, 1'b1, 32'h000000C1, 5'd4);
    fu_valid = 4'b0101;
    tick();
    check_cmp("bp.fu3", 5'd2, 1'b1, 6'd11, 32'h30);
    set_fu(2, 6'd21, 1'b1, 32'h000000C2, 5'd5);
    fu_valid = 4'b0100;
    tick();
    check_cmp("bp.fu0a", 5'd1, 1'b1, 6'd10, 32'hA0);
    set_fu(2, 6'd22, 1'b1, 32'h000000C3, 5'd6);
    check("bp.ready_full", 64'(fu_ready), 64'(4'b1011));
    tick();
    check_cmp("bp.fu2a", 5'd4, 1'b1, 6'd20, 32'hC1);
    check("bp.ready_freed", 64'(fu_ready), 64'(4'b1111));
    tick();
    fu_valid = '0;
    check_cmp("bp.fu0b", 5'd3, 1'b1, 6'd12, 32'hB0);
    tick();
    check_cmp("bp.fu2b", 5'd5, 1'b1, 6'd21, 32'hC2);
    tick();
    check_cmp("bp.fu2c", 5'd6, 1'b1, 6'd22, 32'hC3);
    tick();
    check_idle("bp.after");
    // rr_ptr = 3

    // ---------------- squash with 5 queued entries ----------------
    for (int i = 0; i < NFU; i++)
      set_fu(i, TAG_W'(40 + i), 1'b1, 32'hE0 + 32'(i), ROB_IDX_W'(8 + i));
    fu_valid = 4'b1111;
    tick();
    set_fu(0, 6'd44, 1'b1, 32'hE4, 5'd12);
    set_fu(1, 6'd45, 1'b1, 32'hE5, 5'd13);
    fu_valid = 4'b0011;
    tick();
    check_cmp("sq.pre", 5'd11, 1'b1, 6'd43, 32'hE3);
    squash = 1'b1;
    set_fu(3, 6'd50, 1'b1, 32'h77, 5'd14);
    fu_valid = 4'b1000;
    tick();
    squash   = 1'b0;
    fu_valid = '0;
    check_idle("sq.flushed");
    check("sq.fu_ready", 64'(fu_ready), 64'(4'hF));
    tick();
    check_idle("sq.dropped");
    set_fu(1, 6'd33, 1'b1, 32'h5A, 5'd7);
    fu_valid = 4'b0010;
    tick();
    set_fu(0, 6'd60, 1'b1, 32'h99, 5'd15);
    fu_valid = 4'b0001;
    tick();
    fu_valid = '0;
    check_cmp("sq.resume", 5'd7, 1'b1, 6'd33, 32'h5A);

    // ---------------- asynchronous reset mid-cycle ----------------
    #2;
    reset = 1'b0;
    #1;
    check_idle("arst");
    check("arst.rob_idx", 64'(rob_cmp_idx), 64'd0);
    check("arst.write_data", 64'(ic_prf_packet.write_data), 64'd0);
    check("arst.cdb_tag", 64'(cdb_tag), 64'd0);
    check("arst.fu_ready", 64'(fu_ready), 64'(4'hF));
    #1;
    reset = 1'b1;
    tick();
    check_idle("arst.discard");
    // rr_ptr = 0, all FIFOs empty

    // ---------------- full contention ----------------
    for (int i = 0; i < NFU; i++) begin
      seq[i] = 3'd0;
      set_fu(i, TAG_W'(i * 8 + 1), 1'b1, 32'hF000_0000 | 32'(i << 8), ROB_IDX_W'(i * 8));
    end
    fu_valid = 4'hF;
    for (int k = 1; k <= 13; k++) begin
      acc = fu_ready & fu_valid;
      tick();
      for (int i = 0; i < NFU; i++) begin
        if (acc[i]) seq[i] = seq[i] + 3'd1;
        set_fu(i, TAG_W'(i * 8 + int'(seq[i]) + 1), 1'b1,
               32'hF000_0000 | 32'(i << 8) | 32'(seq[i]), ROB_IDX_W'(i * 8 + int'(seq[i])));
      end
      if (k == 1) check_idle("fc.first");
      if (k == 2) check("fc.ready_k2", 64'(fu_ready), 64'(4'b0001));
      if (k == 3) check("fc.ready_k3", 64'(fu_ready), 64'(4'b0010));
      if (k >= 2) begin
        efu  = (k - 2) % 4;
        eseq = (k - 2) / 4;
        check_cmp($sformatf("fc.k%0d", k), ROB_IDX_W'(efu * 8 + eseq), 1'b1,
                  TAG_W'(efu * 8 + eseq + 1),
                  32'hF000_0000 | 32'(efu << 8) | 32'(eseq));
      end
    end
    fu_valid = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
